dmem_responder: RTL and testbench

//  Responder end of the data-memory load/store interface. Accepts one request at a time

---
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready channels,
// with a programmable number of wait states between accept and access.
module dmem_responder #(
  parameter int unsigned WORD    = 64,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            lat_write;
  logic            lat_err;
  logic [AW-1:0]   lat_idx;
  logic [WORD-1:0] lat_wdata;
  logic            req_err;
  logic [WORD-1:0] mem [DEPTH];

  // Out of range is any set bit above the index field, since DEPTH is a power of two.
  always_comb begin
    req_err = (req_addr[2:0] != '0) || (req_addr[WORD-1:AW+3] != '0);
  end

  // Array has no reset; reset forces state out of ACCESS, so a dropped store never commits.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && lat_write && !lat_err)
      mem[lat_idx] <= lat_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_addr[3 +: AW];
            lat_wdata <= req_wdata;
            wait_cnt  <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1)
            state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rsp_rdata <= (!lat_write && !lat_err) ? mem[lat_idx] : '0;
          rsp_err   <= lat_err;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 (d=0), one at LATENCY=0 (d=1).
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.WORD(64), .DEPTH(128), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.WORD(64), .DEPTH(128), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge and return just after the accepting posedge.
  task automatic issue(input int d, input string tag, input logic wr,
                       input logic [63:0] addr, input logic [63:0] wdata);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, 64'(req_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the responder must ignore them.
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = '1;
    req_wdata[d] = '0;
  endtask

  // Count negedges after the accept edge until rsp_valid is seen, bounded.
  task automatic wait_rsp(input int d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[d] && n < 40);
  endtask

  task automatic transact(input int d, input string tag, input logic wr,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int exp_lat);
    int n;
    rsp_ready[d] = 1'b1;
    issue(d, tag, wr, addr, wdata);
    wait_rsp(d, n);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'd1);
    check({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
    check({tag, "_err"}, 64'(rsp_err[d]), 64'(exp_err));
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(rsp_valid[d]), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready[d]), 64'd1);
  endtask

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_req_ready", 64'(req_ready[i]), 64'd1);
      check("reset_rsp_valid", 64'(rsp_valid[i]), 64'd0);
      check("reset_rsp_rdata", rsp_rdata[i], 64'd0);
      check("reset_rsp_err", 64'(rsp_err[i]), 64'd0);
    end
    rst_n = 1'b1;

    // Store then load at LATENCY=2
    transact(0, "st10", 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 4);
    transact(0, "ld10", 1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 4);

    // Errors: misaligned, out of range, then original data unchanged
    transact(0, "st13", 1'b1, 64'h13, 64'h1111, 64'h0, 1'b1, 4);
    transact(0, "st400", 1'b1, 64'h400, 64'h2222, 64'h0, 1'b1, 4);
    transact(0, "ld408", 1'b0, 64'h408, 64'h0, 64'h0, 1'b1, 4);
    transact(0, "ld_hi", 1'b0, 64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b1, 4);
    transact(0, "ld10b", 1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 4);
    // Highest legal entry
    transact(0, "st3f8", 1'b1, 64'h3F8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 4);
    transact(0, "ld3f8", 1'b0, 64'h3F8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 4);

    // Back-pressure on a load response
    rsp_ready[0] = 1'b0;
    issue(0, "bp", 1'b0, 64'h10, 64'h0);
    wait_rsp(0, n);
    check("bp_latency", 64'(n), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid[0]), 64'd1);
      check("bp_rdata", rsp_rdata[0], 64'hDEADBEEF_CAFEF00D);
      check("bp_err", 64'(rsp_err[0]), 64'd0);
      check("bp_req_ready", 64'(req_ready[0]), 64'd0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 64'(rsp_valid[0]), 64'd0);
    check("bp_ready_back", 64'(req_ready[0]), 64'd1);

    // Asynchronous reset asserted mid-cycle while a response is held
    rsp_ready[0] = 1'b0;
    issue(0, "ar", 1'b0, 64'h3F8, 64'h0);
    wait_rsp(0, n);
    check("ar_pre_valid", 64'(rsp_valid[0]), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_req_ready", 64'(req_ready[0]), 64'd1);
    check("ar_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("ar_rsp_rdata", rsp_rdata[0], 64'd0);
    check("ar_rsp_err", 64'(rsp_err[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;

    // LATENCY=0 instance
    transact(1, "l0_st0", 1'b1, 64'h0, 64'h1, 64'h0, 1'b0, 2);
    transact(1, "l0_ld0", 1'b0, 64'h0, 64'h0, 64'h1, 1'b0, 2);
    transact(1, "l0_mis", 1'b0, 64'h4, 64'h0, 64'h0, 1'b1, 2);

    // Reset during WAIT drops a store
    transact(0, "st20", 1'b1, 64'h20, 64'hAAAA, 64'h0, 1'b0, 4);
    issue(0, "drop", 1'b1, 64'h20, 64'h5555);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    check("drop_no_rsp", 64'(seen), 64'd0);
    transact(0, "ld20", 1'b0, 64'h20, 64'h0, 64'hAAAA, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
